// File: rtl/pixel_ctrl_pkg.sv
// Shared types and widths for the pixel array sequencer.
// Imported by the interface, the drain stage and the top.
package pixel_pkg;

  localparam int PIX_W       = 8;
  localparam int N_PIX       = 4;
  localparam int PHASE_CNT_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_READ,
    S_DRAIN
  } pixel_state_t;

endpackage

// File: rtl/pixel_ctrl_if.sv
// Array control/readout bus plus the pixel stream toward the frame buffer.
// The controller is the master end.
interface pixel_ctrl_if;
  import pixel_pkg::*;

  logic       ERASE;
  logic       EXPOSE;
  logic       CONVERT;
  logic       READ;
  logic       RAMP;
  pix_t       DATA1;
  pix_t       DATA2;
  pix_t       DATA3;
  pix_t       DATA4;
  pix_t       OUT_DATA;
  logic [1:0] OUT_PIX;
  logic       OUT_VALID;
  logic       OUT_READY;

  modport master (
    output ERASE, EXPOSE, CONVERT, READ, RAMP,
    output OUT_DATA, OUT_PIX, OUT_VALID,
    input  DATA1, DATA2, DATA3, DATA4,
    input  OUT_READY
  );

  modport slave (
    input  ERASE, EXPOSE, CONVERT, READ, RAMP,
    input  OUT_DATA, OUT_PIX, OUT_VALID,
    output DATA1, DATA2, DATA3, DATA4,
    output OUT_READY
  );

endinterface

// File: rtl/pixel_ctrl_drain.sv
// Capture buffer and valid/ready drain of the four pixel codes.
// OUT_DATA is loaded straight from the array on capture so it stays registered.
module pixel_ctrl_drain
  import pixel_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic                        abort,
  input  logic                        start_drain,
  input  logic [N_PIX-1:0][PIX_W-1:0] data,
  input  logic                        ready,
  output pix_t                        out_data,
  output logic [1:0]                  out_pix,
  output logic                        out_valid,
  output logic                        done
);

  logic [N_PIX-1:0][PIX_W-1:0] pbuf;
  logic                        accept;
  logic [1:0]                  pix_inc;

  assign accept  = out_valid & ready & ~abort;
  assign done    = accept && (out_pix == 2'(N_PIX - 1));
  assign pix_inc = out_pix + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbuf      <= '0;
      out_data  <= '0;
      out_pix   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (capture)
        pbuf <= data;
      if (abort) begin
        out_valid <= 1'b0;
      end else if (start_drain) begin
        out_valid <= 1'b1;
        out_pix   <= '0;
        out_data  <= data[0];
      end else if (accept) begin
        out_pix <= pix_inc;
        if (done)
          out_valid <= 1'b0;
        else
          out_data <= pbuf[pix_inc];
      end
    end
  end

endmodule

// File: rtl/pixel_ctrl.sv
// Frame sequencer: ERASE/EXPOSE/CONVERT/READ phases, RAMP strobe, then drain.
// All outputs are registered from the next-state decode.
module pixel_ctrl
  import pixel_pkg::*;
#(
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 100,
  parameter int CONVERT_STEPS = 255,
  parameter int READ_CYCLES   = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         ABORT,
  output logic         BUSY,
  output logic         FRAME_DONE,
  pixel_ctrl_if.master bus
);

  localparam logic [PHASE_CNT_W-1:0] LAST_ER =
    PHASE_CNT_W'(ERASE_CYCLES - 1);
  localparam logic [PHASE_CNT_W-1:0] LAST_EX =
    PHASE_CNT_W'(EXPOSE_CYCLES - 1);
  localparam logic [PHASE_CNT_W-1:0] LAST_CV =
    PHASE_CNT_W'(2 * CONVERT_STEPS - 1);
  localparam logic [PHASE_CNT_W-1:0] LAST_RD =
    PHASE_CNT_W'(READ_CYCLES - 1);

  pixel_state_t           state;
  pixel_state_t           nxt;
  logic [PHASE_CNT_W-1:0] cnt;
  logic [PHASE_CNT_W-1:0] cnt_nxt;
  logic                   capture;
  logic                   drain_done;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    capture = 1'b0;
    unique case (state)
      S_IDLE:    if (START) nxt = S_ERASE;
      S_ERASE:   if (cnt == LAST_ER) nxt = S_EXPOSE;
      S_EXPOSE:  if (cnt == LAST_EX) nxt = S_CONVERT;
      S_CONVERT: if (cnt == LAST_CV) nxt = S_READ;
      S_READ: begin
        if (cnt == LAST_RD) begin
          nxt     = S_DRAIN;
          capture = 1'b1;
        end
      end
      S_DRAIN:   if (drain_done) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
    if (ABORT && state != S_IDLE) begin
      nxt     = S_IDLE;
      capture = 1'b0;
    end
    // phase counter restarts at zero on every state entry
    if (nxt != state || state == S_IDLE)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + PHASE_CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.ERASE   <= 1'b0;
      bus.EXPOSE  <= 1'b0;
      bus.CONVERT <= 1'b0;
      bus.READ    <= 1'b0;
      bus.RAMP    <= 1'b0;
      BUSY        <= 1'b0;
      FRAME_DONE  <= 1'b0;
    end else begin
      bus.ERASE   <= nxt == S_ERASE;
      bus.EXPOSE  <= nxt == S_EXPOSE;
      bus.CONVERT <= nxt == S_CONVERT;
      bus.READ    <= nxt == S_READ;
      // odd phase index -> one rising edge per step pair
      bus.RAMP    <= (nxt == S_CONVERT) && cnt_nxt[0];
      BUSY        <= nxt != S_IDLE;
      FRAME_DONE  <= (state == S_DRAIN) && drain_done && !ABORT;
    end
  end

  pixel_ctrl_drain u_drain (
    .clk         (CLK),
    .rst         (RESET),
    .capture     (capture),
    .abort       (ABORT),
    .start_drain (capture),
    .data        ({bus.DATA4, bus.DATA3, bus.DATA2, bus.DATA1}),
    .ready       (bus.OUT_READY),
    .out_data    (bus.OUT_DATA),
    .out_pix     (bus.OUT_PIX),
    .out_valid   (bus.OUT_VALID),
    .done        (drain_done)
  );

endmodule

// File: tb/tb_pixel_ctrl.sv
// Self-checking bench for pixel_ctrl: frame-timeline model per cycle.
module tb_pixel_ctrl;
  import pixel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic abort = 1'b0;
  logic busy0, busy1, done0, done1;
  logic [7:0] d [4];
  int checks = 0;
  int errors = 0;

  pixel_ctrl_if b0 ();
  pixel_ctrl_if b1 ();

  pixel_ctrl dut0 (
    .CLK(clk), .RESET(rst), .START(start0), .ABORT(abort),
    .BUSY(busy0), .FRAME_DONE(done0), .bus(b0.master)
  );

  pixel_ctrl #(
    .ERASE_CYCLES(3), .EXPOSE_CYCLES(7),
    .CONVERT_STEPS(10), .READ_CYCLES(3)
  ) dut1 (
    .CLK(clk), .RESET(rst), .START(start1), .ABORT(abort),
    .BUSY(busy1), .FRAME_DONE(done1), .bus(b1.master)
  );

  always #5 clk = ~clk;

  // [17]ER [16]EX [15]CV [14]RD [13]RAMP [12]VALID [11]BUSY [10]DONE
  logic [17:0] o0, o1;
  assign o0 = {b0.ERASE, b0.EXPOSE, b0.CONVERT, b0.READ, b0.RAMP,
               b0.OUT_VALID, busy0, done0, b0.OUT_PIX, b0.OUT_DATA};
  assign o1 = {b1.ERASE, b1.EXPOSE, b1.CONVERT, b1.READ, b1.RAMP,
               b1.OUT_VALID, busy1, done1, b1.OUT_PIX, b1.OUT_DATA};

  task automatic drive_data();
    b0.DATA1 = d[0]; b0.DATA2 = d[1]; b0.DATA3 = d[2]; b0.DATA4 = d[3];
    b1.DATA1 = d[0]; b1.DATA2 = d[1]; b1.DATA3 = d[2]; b1.DATA4 = d[3];
  endtask

  task automatic set_ready(input logic r);
    b0.OUT_READY = r;
    b1.OUT_READY = r;
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    drive_data();
  endtask

  // rmode: 0 ready always, 1 random ready, 2 three stall cycles at pixel 1
  task automatic run_frame(input int sel, input bit do_start,
                           input bit hold, input int rmode,
                           input int abort_at,
                           output int len, output int ramps);
    int e, x, c, r, dstart, mp, stall, ci;
    logic [17:0] o;
    logic [7:0] exp_ctl;
    logic e_cv, e_valid, e_done, prev_ramp, rdy;
    if (sel == 0) begin e = 4; x = 100; c = 255; r = 2; end
    else          begin e = 3; x = 7;   c = 10;  r = 3; end
    dstart = e + x + 2 * c + r + 1;
    mp = 0; stall = 0; len = 0; ramps = 0; prev_ramp = 1'b0;
    if (do_start) begin
      @(negedge clk);
      set_start(sel, 1'b1);
    end
    for (int t = 1; t <= 5000; t++) begin
      @(negedge clk);
      o = (sel == 0) ? o0 : o1;
      ci = t - (e + x + 1);
      e_cv = (ci >= 0) && (ci < 2 * c);
      e_valid = (t >= dstart) && (mp < 4);
      e_done = (t >= dstart) && (mp == 4);
      exp_ctl = {t <= e, (t > e) && (t <= e + x), e_cv,
                 (t > e + x + 2 * c) && (t <= e + x + 2 * c + r),
                 e_cv && (ci % 2 == 1), e_valid, !e_done, e_done};
      if (abort_at != 0 && t == abort_at + 1) exp_ctl = 8'h00;
      checks++;
      if (o[17:10] !== exp_ctl) begin
        errors++;
        $display("FAIL ctl dut%0d t=%0d got %b want %b",
                 sel, t, o[17:10], exp_ctl);
      end
      if (e_valid && !(abort_at != 0 && t == abort_at + 1)) begin
        checks++;
        if (o[9:0] !== {2'(mp), d[mp]}) begin
          errors++;
          $display("FAIL pix dut%0d t=%0d got %0d/%h want %0d/%h",
                   sel, t, o[9:8], o[7:0], mp, d[mp]);
        end
      end
      if (o[13] && !prev_ramp && o[15]) ramps++;
      prev_ramp = o[13];
      if (abort_at != 0 && t == abort_at + 1) begin
        abort = 1'b0;
        len = t;
        break;
      end
      if (e_done) begin
        set_start(sel, hold);
        len = t;
        break;
      end
      if (hold) set_start(sel, 1'b1);
      else if (abort_at != 0) set_start(sel, 1'b0);
      else set_start(sel, 1'($urandom % 2));
      abort = (t == abort_at);
      unique case (rmode)
        0: rdy = 1'b1;
        1: rdy = ($urandom % 3) != 0;
        default: begin
          rdy = 1'b1;
          if (e_valid && mp == 1 && stall < 3) begin
            rdy = 1'b0;
            stall++;
          end
        end
      endcase
      set_ready(rdy);
      if (e_valid && rdy && t != abort_at) mp++;
    end
    abort = 1'b0;
    if (len == 0) begin
      errors++;
      $display("FAIL timeout dut%0d got no frame end want end", sel);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (o0 !== 18'h0 || o1 !== 18'h0) begin
      errors++;
      $display("FAIL reset got %h/%h want 0", o0, o1);
    end
  endtask

  task automatic test_basic();
    int len, ramps;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    drive_data();
    run_frame(0, 1'b1, 1'b0, 0, 0, len, ramps);
    checks++;
    if (len !== 621) begin
      errors++;
      $display("FAIL basic_len got %0d want 621", len);
    end
    checks++;
    if (ramps !== 255) begin
      errors++;
      $display("FAIL basic_ramps got %0d want 255", ramps);
    end
  endtask

  task automatic test_convert_steps();
    int len, ramps;
    rand_data();
    run_frame(1, 1'b1, 1'b0, 0, 0, len, ramps);
    checks++;
    if (ramps !== 10) begin
      errors++;
      $display("FAIL steps_ramps got %0d want 10", ramps);
    end
    checks++;
    if (len !== 38) begin
      errors++;
      $display("FAIL steps_len got %0d want 38", len);
    end
    rand_data();
    run_frame(1, 1'b1, 1'b0, 1, 0, len, ramps);
  endtask

  task automatic test_backpressure();
    int len, ramps;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    drive_data();
    run_frame(0, 1'b1, 1'b0, 2, 0, len, ramps);
    checks++;
    if (len !== 624) begin
      errors++;
      $display("FAIL stall_len got %0d want 624", len);
    end
    rand_data();
    run_frame(0, 1'b1, 1'b0, 1, 0, len, ramps);
  endtask

  task automatic test_abort();
    int len, ramps;
    rand_data();
    run_frame(0, 1'b1, 1'b0, 1, 300, len, ramps);
    checks++;
    if (len !== 301) begin
      errors++;
      $display("FAIL abort_len got %0d want 301", len);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle got busy=%b done=%b want 0/0",
                 busy0, done0);
      end
    end
    rand_data();
    run_frame(0, 1'b1, 1'b0, 0, 0, len, ramps);
    checks++;
    if (len !== 621) begin
      errors++;
      $display("FAIL abort_next got %0d want 621", len);
    end
  endtask

  task automatic test_reset_midframe();
    int len, ramps;
    rand_data();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (49) @(negedge clk);
    checks++;
    if (b0.EXPOSE !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got EXPOSE=%b want 1", b0.EXPOSE);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (o0 !== 18'h0) begin
      errors++;
      $display("FAIL rst_async got %h want 0", o0);
    end
    start0 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o0 !== 18'h0) begin
      errors++;
      $display("FAIL rst_hold got %h want 0", o0);
    end
    start0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o0 !== 18'h0) begin
      errors++;
      $display("FAIL rst_idle got %h want 0", o0);
    end
    run_frame(0, 1'b1, 1'b0, 1, 0, len, ramps);
  endtask

  task automatic test_back_to_back();
    int len1, len2, ramps;
    rand_data();
    run_frame(0, 1'b1, 1'b1, 0, 0, len1, ramps);
    rand_data();
    run_frame(0, 1'b0, 1'b0, 0, 0, len2, ramps);
    checks++;
    if (len1 !== 621 || len2 !== 621) begin
      errors++;
      $display("FAIL b2b_len got %0d/%0d want 621/621", len1, len2);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b want 0", busy0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) d[i] = 8'h00;
    drive_data();
    set_ready(1'b1);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic();
    test_convert_steps();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_ctrl.md
# pixel_ctrl

Frame sequencer and readout initiator for the 4-pixel array. It drives the array's phase controls (ERASE, EXPOSE, CONVERT, READ) and the ADC RAMP strobe. It captures the array's four latched 8-bit pixel codes and drains them one per handshake on a valid/ready stream toward the frame buffer. It is the master end of the array's control/readout interface.

## Interface
- ERASE_CYCLES, 4, cycles ERASE held high (1..255)
- EXPOSE_CYCLES, 100, cycles EXPOSE held high (1..65535)
- CONVERT_STEPS, 255, RAMP rising edges per conversion (1..255; array counter is 8 bit)
- READ_CYCLES, 2, cycles READ held high (2..15)

- CLK  in  1  system clock, rising edge
- RESET  in  1  reset, asynchronous, active-high; also fans out to the array
- START  in  1  request one frame; sampled only in IDLE
- ABORT  in  1  synchronous abort; returns to IDLE
- DATA1..DATA4  in  8 each  array readout registers
- ERASE, EXPOSE, CONVERT, READ  out  1 each  array phase controls
- RAMP  out  1  ADC step strobe; array counts on its rising edge
- OUT_DATA  out  8  pixel code
- OUT_PIX  out  2  pixel index 0..3 (DATA1..DATA4)
- OUT_VALID  out  1  OUT_DATA/OUT_PIX valid
- OUT_READY  in  1  sink accepts when high with OUT_VALID
- BUSY  out  1  frame in progress
- FRAME_DONE  out  1  one-cycle pulse after pixel 3 accepted

## Operation
- All outputs are registered and are 0 in reset.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, DRAIN. One 16-bit phase counter is reloaded on every state entry.
- IDLE: START=1 -> ERASE.
- ERASE: ERASE=1 for ERASE_CYCLES, then EXPOSE.
- EXPOSE: EXPOSE=1 for EXPOSE_CYCLES, then CONVERT.
- CONVERT: CONVERT=1 for 2·CONVERT_STEPS cycles.
  - RAMP=0 on even phase-cycle index and 1 on odd index, starting at index 0. This gives exactly CONVERT_STEPS rising edges, each while CONVERT=1.
  - RAMP=0 whenever CONVERT=0.
  - Then READ.
- READ: READ=1 for READ_CYCLES. DATA1..4 are sampled into a 4×8 buffer at the clock edge that ends the last READ cycle. Then DRAIN.
- DRAIN:
  - OUT_VALID=1, OUT_PIX starts at 0, OUT_DATA=buf[OUT_PIX].
  - On OUT_VALID&OUT_READY, OUT_PIX increments.
  - OUT_DATA/OUT_PIX stay stable while OUT_VALID=1 and OUT_READY=0.
  - After pixel 3 is accepted: OUT_VALID=0, FRAME_DONE=1 for one cycle, BUSY=0, state IDLE.
- BUSY=1 in every state except IDLE.
- Exactly one phase control is high at any time; none in IDLE or DRAIN.
- ABORT (any non-IDLE state): next cycle all controls, RAMP, OUT_VALID and BUSY are 0, state IDLE, no FRAME_DONE. ABORT has priority over START and handshake.
- START outside IDLE is ignored. START held high restarts one cycle after FRAME_DONE (START is sampled in IDLE).
- RESET mid-frame: all outputs 0 immediately; the buffer is cleared to 0.

## Timing
- START sampled at edge 0 (defaults, OUT_READY=1):
  - ERASE high cycles 1–4
  - EXPOSE high cycles 5–104
  - CONVERT high cycles 105–614; RAMP rises in cycles 106, 108, …, 614
  - READ high cycles 615–616; capture at edge 617
  - OUT_VALID high cycles 617–620 (OUT_PIX 0..3)
  - FRAME_DONE and BUSY=0 at cycle 621
- General frame length with no backpressure: ERASE_CYCLES+EXPOSE_CYCLES+2·CONVERT_STEPS+READ_CYCLES+4 cycles, then FRAME_DONE.
- Each OUT_READY=0 cycle during DRAIN adds exactly one cycle.
- READ_CYCLES≥2 guarantees the array's READ-edge latch has settled before capture.

## Structure
- Package pixel_pkg:
  - state enum pixel_state_t
  - PIX_W=8, N_PIX=4, PHASE_CNT_W=16
- Sub-module pixel_ctrl_drain: 4×8 capture buffer, index counter and valid/ready logic; inputs capture/abort/start_drain; output done.
- The FSM and phase counter stay in pixel_ctrl.

## Test plan
- Defaults, DATA1..4=8'h11,22,33,44 static, OUT_READY=1, START pulse -> phase windows exactly as in Timing; outputs (0,11),(1,22),(2,33),(3,44); FRAME_DONE at cycle 621.
- CONVERT_STEPS=10 -> exactly 10 RAMP rising edges, all with CONVERT=1; RAMP=0 outside CONVERT.
- OUT_READY low for 3 cycles at OUT_PIX=1 -> OUT_DATA stays 8'h22 for those cycles; FRAME_DONE delayed by 3 cycles.
- ABORT asserted at cycle 300 (CONVERT) -> at cycle 301 CONVERT=RAMP=BUSY=0, no FRAME_DONE; next START gives a full normal frame.
- RESET asserted mid-EXPOSE -> all outputs 0 asynchronously; after release, IDLE, with START ignored until sampled in IDLE.
- START held high continuously -> back-to-back frames; second ERASE begins the cycle after FRAME_DONE; START pulses during a frame have no effect.
